// File: rtl/count_sweep_monitor.sv
// -----------------------------------------------------------------------------
// count_sweep_monitor
//
// Passive observer for a bouncing up/down counter. It samples the counter's
// output bus and does four things. It recovers the counting direction. It
// flags the peak and trough turnarounds. It detects illegal steps, which are
// jumps, wraps and reversals that do not happen at an end. It counts completed
// sweeps, where one sweep is a trough turnaround. The monitor never drives the
// counter. It sits in the counter's clock domain.
//
// Optional feature macro: CNT_MON_IRQ_EN
//   When defined, the module gains a sticky error interrupt (err_irq). The
//   interrupt is set by any illegal step and cleared by irq_clr. If a set and
//   a clear arrive in the same cycle, the set wins.
//
// Ports
//   clk        in   1      clock, all logic on rising edge
//   asyn_rst   in   1      asynchronous reset, active-high
//   smp_vld    in   1      sample strobe; count_in is evaluated only when 1
//   resync     in   1      with smp_vld: the counter was loaded, so re-acquire
//                          without raising an error
//   count_in   in   WIDTH  observed counter value
//   irq_clr    in   1      (CNT_MON_IRQ_EN only) clears err_irq
//   dir_valid  out  1      direction locked (state UP or DOWN)
//   dir_up     out  1      1 = ascending; meaningful only when dir_valid
//   turn_pulse out  1      one-cycle pulse on a peak or trough turnaround
//   err_pulse  out  1      one-cycle pulse on an illegal step
//   err_irq    out  1      (CNT_MON_IRQ_EN only) sticky error flag
//   err_cnt    out  ERR_W  illegal steps seen, saturating at all-ones
//   sweep_cnt  out  SWP_W  completed troughs, wraps around
//
// All outputs are registered. The response to a strobe appears in the cycle
// after the edge that sampled it.
// -----------------------------------------------------------------------------
module count_sweep_monitor #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8,
    parameter int SWP_W = 8
) (
    input  logic             clk,
    input  logic             asyn_rst,
    input  logic             smp_vld,
    input  logic             resync,
    input  logic [WIDTH-1:0] count_in,
`ifdef CNT_MON_IRQ_EN
    input  logic             irq_clr,
    output logic             err_irq,
`endif
    output logic             dir_valid,
    output logic             dir_up,
    output logic             turn_pulse,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [SWP_W-1:0] sweep_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [ERR_W-1:0] ERR_SAT  = {ERR_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             turn_q, turn_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [SWP_W-1:0] sweep_q, sweep_d;

    // Events decided by the next-state logic and consumed by the output logic.
    logic             ev_err;
    logic             ev_turn;
    logic             ev_sweep;

    // Step classification against the previous sample. The range guards stop
    // MAX->0 and 0->MAX from being read as +1/-1, because the counter bounces
    // at its ends and never wraps.
    logic             is_stall;
    logic             is_inc;
    logic             is_dec;

    always_comb begin
        is_stall = (count_in == prev_q);
        is_inc   = (count_in == prev_q + WIDTH'(1)) && (prev_q != MAX_VAL);
        is_dec   = (count_in == prev_q - WIDTH'(1)) && (prev_q != ZERO_VAL);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            turn_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            sweep_q   <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            turn_q    <= turn_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            sweep_q   <= sweep_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        ev_err   = 1'b0;
        ev_turn  = 1'b0;
        ev_sweep = 1'b0;

        if (smp_vld) begin
            // Every accepted sample becomes the new reference, even when the
            // step was illegal. This lets SYNC re-acquire from the new value.
            prev_d = count_in;

            if (resync) begin
                // The counter was loaded, so the jump is expected.
                state_d = SYNC;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_d = SYNC;
                    end

                    SYNC: begin
                        if (is_inc) begin
                            state_d = UP;
                        end else if (is_dec) begin
                            state_d = DOWN;
                        end else if (!is_stall) begin
                            ev_err = 1'b1;
                        end
                    end

                    UP: begin
                        if (is_stall) begin
                            state_d = UP;
                        end else if (prev_q == MAX_VAL) begin
                            // At the peak, the only legal move is back down.
                            if (is_dec) begin
                                state_d = DOWN;
                                ev_turn = 1'b1;
                            end else begin
                                state_d = SYNC;
                                ev_err  = 1'b1;
                            end
                        end else if (!is_inc) begin
                            state_d = SYNC;
                            ev_err  = 1'b1;
                        end
                    end

                    DOWN: begin
                        if (is_stall) begin
                            state_d = DOWN;
                        end else if (prev_q == ZERO_VAL) begin
                            // Trough turnaround completes one sweep.
                            if (is_inc) begin
                                state_d  = UP;
                                ev_turn  = 1'b1;
                                ev_sweep = 1'b1;
                            end else begin
                                state_d = SYNC;
                                ev_err  = 1'b1;
                            end
                        end else if (!is_dec) begin
                            state_d = SYNC;
                            ev_err  = 1'b1;
                        end
                    end

                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // -------------------------------------------------------------------------
    always_comb begin
        turn_d    = ev_turn;
        err_d     = ev_err;
        err_cnt_d = err_cnt_q;
        sweep_d   = sweep_q;

        if (ev_err && (err_cnt_q != ERR_SAT)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end

        if (ev_sweep) begin
            sweep_d = sweep_q + SWP_W'(1);
        end
    end

`ifdef CNT_MON_IRQ_EN
    logic irq_q, irq_d;

    // A new error takes priority over a clear in the same cycle.
    always_comb begin
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (ev_err) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign err_irq = irq_q;
`endif

    assign dir_valid  = (state_q == UP) || (state_q == DOWN);
    assign dir_up     = (state_q == UP);
    assign turn_pulse = turn_q;
    assign err_pulse  = err_q;
    assign err_cnt    = err_cnt_q;
    assign sweep_cnt  = sweep_q;

endmodule
